// File: rtl/u_receiver_param_if.sv
// rtl/u_receiver_param_if.sv - serial line in, received frame results out
interface u_receiver_param_if #(
   parameter int data_bits = 8
);
   logic                 serial_data;
   logic [data_bits-1:0] parallel_data;
   logic                 data_valid;
   logic                 parity_error;
   logic                 frame_error;
   logic                 active;

   // master drives the line and consumes frames; slave is the receiver
   modport master (
      output serial_data,
      input  parallel_data, data_valid, parity_error, frame_error, active
   );
   modport slave (
      input  serial_data,
      output parallel_data, data_valid, parity_error, frame_error, active
   );
endinterface

// File: rtl/u_receiver_param.sv
// rtl/u_receiver_param.sv - parameterised UART receiver with mid-bit sampling
module u_receiver_param #(
   parameter int clocks_per_bit = 130,
   parameter int data_bits      = 8,
   parameter int parity_mode    = 0,
   parameter int stop_bits      = 1
) (
   input  logic               clk,
   input  logic               rst,
   u_receiver_param_if.slave  rx_if
);
   localparam int CW = $clog2(clocks_per_bit);
   localparam logic [CW-1:0] CNT_LAST = CW'(clocks_per_bit - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'((clocks_per_bit - 1) / 2);
   localparam logic [3:0]    IDX_DATA_LAST = 4'(data_bits - 1);
   localparam logic [3:0]    IDX_STOP_LAST = 4'(stop_bits - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [3:0]           idx_q, idx_d;
   logic [1:0]           sync_q, sync_d;
   logic [data_bits-1:0] shift_q, shift_d;
   logic                 par_flag_q, par_flag_d;
   logic                 frm_flag_q, frm_flag_d;
   logic [data_bits-1:0] data_q, data_d;
   logic                 dv_q, dv_d;
   logic                 pe_q, pe_d;
   logic                 fe_q, fe_d;
   logic                 line;
   logic                 par_exp;

   assign line    = sync_q[1];
   // even parity bit is the XOR of the payload; odd parity inverts it
   assign par_exp = (^shift_q) ^ (parity_mode == 2);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         sync_q     <= 2'b11;
         shift_q    <= '0;
         par_flag_q <= 1'b0;
         frm_flag_q <= 1'b0;
         data_q     <= '0;
         dv_q       <= 1'b0;
         pe_q       <= 1'b0;
         fe_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         sync_q     <= sync_d;
         shift_q    <= shift_d;
         par_flag_q <= par_flag_d;
         frm_flag_q <= frm_flag_d;
         data_q     <= data_d;
         dv_q       <= dv_d;
         pe_q       <= pe_d;
         fe_q       <= fe_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      sync_d     = {sync_q[0], rx_if.serial_data};
      shift_d    = shift_q;
      par_flag_d = par_flag_q;
      frm_flag_d = frm_flag_q;
      data_d     = data_q;
      dv_d       = 1'b0;
      pe_d       = pe_q;
      fe_d       = fe_q;

      unique case (state_q)
         S_IDLE: begin
            idx_d      = '0;
            cnt_d      = '0;
            par_flag_d = 1'b0;
            frm_flag_d = 1'b0;
            if (!line) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               idx_d   = '0;
               // a line that is high again at mid-start was only a glitch
               state_d = line ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shift_d = {line, shift_q[data_bits-1:1]};
               if (idx_q == IDX_DATA_LAST) begin
                  idx_d   = '0;
                  state_d = (parity_mode != 0) ? S_PARITY : S_STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d      = '0;
               idx_d      = '0;
               par_flag_d = par_flag_q | (line != par_exp);
               state_d    = S_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d      = '0;
               frm_flag_d = frm_flag_q | !line;
               if (idx_q == IDX_STOP_LAST) begin
                  idx_d   = '0;
                  dv_d    = 1'b1;
                  data_d  = shift_q;
                  pe_d    = par_flag_d;
                  fe_d    = frm_flag_d;
                  // a low stop bit may be a break; wait for the line to recover
                  state_d = frm_flag_d ? S_WAIT_HIGH : S_IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT_HIGH: begin
            if (line) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rx_if.parallel_data = data_q;
   assign rx_if.data_valid    = dv_q;
   assign rx_if.parity_error  = pe_q;
   assign rx_if.frame_error   = fe_q;
   assign rx_if.active        = (state_q == S_START) || (state_q == S_DATA) ||
                                (state_q == S_PARITY) || (state_q == S_STOP);
endmodule
